// File: rtl/fetch_unit.sv
// fetch_unit: PC-driven ROM fetch with credit-limited instruction FIFO and jump flush.
module fetch_unit #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_value,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] rom_addr,
  output logic             rom_en,
  input  logic [WIDTH-1:0] rom_data,
  input  logic             jump_req,
  input  logic [WIDTH-1:0] jump_addr,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] iaddr_q, iaddr_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] tag_q [DEPTH];
  logic             pop, push, issue;
  logic [CW:0]      credit;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    instr_valid = count_q != '0;
    pop         = instr_valid & instr_ready;
    push        = inflight_q & ~jump_req;
    // Occupancy including the word still on the ROM bus; a pop this cycle frees a slot.
    credit      = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    issue       = ~reset & ~jump_req & (credit < (CW+1)'(DEPTH));
    rom_en      = issue;
    pc_inc      = issue;
    pc_load     = ~reset & jump_req;
    pc_in       = jump_addr;
    rom_addr    = pc_value;
    instr       = instr_valid ? data_q[rd_q] : '0;
    instr_pc    = instr_valid ? tag_q[rd_q] : '0;
    count_d     = jump_req ? '0 : count_q + CW'(push) - CW'(pop);
    rd_d        = jump_req ? '0 : (pop ? nxt(rd_q) : rd_q);
    wr_d        = jump_req ? '0 : (push ? nxt(wr_q) : wr_q);
    inflight_d  = issue;
    iaddr_d     = issue ? pc_value : iaddr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      inflight_q <= 1'b0;
      iaddr_q    <= '0;
    end else begin
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      inflight_q <= inflight_d;
      iaddr_q    <= iaddr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push & ~reset) begin
      data_q[wr_q] <= rom_data;
      tag_q[wr_q]  <= iaddr_q;
    end
  end
endmodule
